chunked_serial_subtractor: RTL
==============================

// Module: chunked_serial_subtractor
// PURPOSE
//  Multi-cycle, parametrised borrow-chain subtractor: diff = a - b - b_in over WIDTH bits.
//  Processes CHUNK bits per cycle, registering the inter-chunk borrow.
//  Trades latency for area against the flat ripple subtractors.
//  Sits between operand producers and consumers with valid/ready handshakes on both sides.
//  Adds signed-overflow and zero flags.
// PARAMETERS
//  WIDTH  32  operand/result width; WIDTH >= 2
//  CHUNK  8   bits subtracted per cycle; WIDTH % CHUNK == 0 (elaboration error otherwise)
//  NCHUNK = WIDTH/CHUNK (localparam, not overridable)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands a, b, b_in valid
//  in_ready   out  1      block can accept an operation (high only in IDLE)
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  b_in       in   1      borrow in, applied to chunk 0
//  out_valid  out  1      result valid, held until consumed
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  (a - b - b_in) mod 2^WIDTH
//  b_out      out  1      borrow out of MSB (1 when unsigned a < b + b_in)
//  ovf        out  1      signed overflow: (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB])
//  zero       out  1      diff == 0
// BEHAVIOUR
//  Reset/interface
//  - One clock domain: clk. Reset rst is synchronous and active-high.
//  - Reset forces state IDLE, chunk index 0, borrow reg 0.
//  - Reset clears out_valid, diff, b_out, ovf and zero to 0.
//  - Any handshake in a cycle with rst=1 is ignored.
//  States
//  - IDLE: in_ready=1. On in_valid&in_ready edge, capture a, b and b_in into borrow reg; idx=0; go RUN.
//  - RUN: each edge subtracts chunk idx (a_q, b_q slice, borrow reg) and writes the diff slice.
//    Each RUN edge also updates the borrow reg and increments idx.
//    After the edge processing idx=NCHUNK-1, go DONE with out_valid=1.
//    At that edge b_out=final borrow; ovf and zero are computed from the full result.
//  - DONE: outputs stable. On out_valid&out_ready edge, out_valid->0 and go IDLE.
//  Latency and throughput
//  - out_valid rises exactly NCHUNK cycles after the accept edge.
//  - in_ready=0 in RUN and DONE, so in_valid there is ignored; no back-to-back accept from DONE.
//  - Minimum initiation interval is NCHUNK+2 cycles.
//  Boundaries
//  - NCHUNK=1 gives latency 1.
//  - Inputs may change freely after accept; operands are registered.
//  - Reset mid-RUN or mid-DONE abandons the operation; no partial result is exposed.
//  - diff is undefined-but-stable while out_valid=0; the bench checks it only when out_valid=1.
// STRUCTURE
//  - Shared header sub_defs.vh holds the state encodings (IDLE=0, RUN=1, DONE=2; 2-bit).
//  - The same header holds the WIDTH%CHUNK check macro.
//  - Sub-module chunk_subtractor #(CHUNK): combinational CHUNK-bit ripple of
//    full-subtractor cells (a, b, b_in -> diff, b_out).
//  - Top level holds the FSM, the idx counter ($clog2(NCHUNK)+1 bits), operand regs, borrow reg,
//    the result reg, and the flag logic.
// TESTING (WIDTH=32, CHUNK=8 unless noted)
//  - Case 1: a=46, b=47, b_in=0 -> diff=32'hFFFFFFFF, b_out=1, ovf=0, zero=0.
//    out_valid exactly 4 cycles after the accept edge.
//  - Case 2: a=110, b=1, b_in=1 -> diff=108, b_out=0.
//    a=46, b=46, b_in=0 -> diff=0, zero=1.
//  - Case 3: a=32'h80000000, b=1, b_in=0 -> diff=32'h7FFFFFFF, ovf=1, b_out=0.
//    a=0, b=0, b_in=1 -> diff=32'hFFFFFFFF, b_out=1, ovf=0.
//  - Case 4 (backpressure): hold out_ready=0 for 5 cycles with in_valid=1 and new operands.
//    -> outputs stable, in_ready=0, second op accepted only after out_ready handshake.
//  - Case 5 (reset): assert rst 2 cycles into RUN -> out_valid=0 next cycle, in_ready=1.
//    Next op 1100-46 -> diff=1054.
//  - Case 6 (config): WIDTH=8, CHUNK=8, a=8'h12, b=8'h03, b_in=1 -> diff=8'h0E, latency 1.
//    Also run 1000 random ops vs a reference model at WIDTH=25, CHUNK=5.

Source files
------------

// File: rtl/chunked_serial_subtractor_pkg.sv
// Shared types and elaboration helpers for the chunked serial subtractor.
package chunked_serial_subtractor_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Legal geometry: at least two bits, non-zero chunk, whole number of chunks.
   function automatic bit geometry_ok(input int unsigned width, input int unsigned chunk);
      return (width >= 2) && (chunk != 0) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/chunked_serial_subtractor_chunk.sv
// Combinational CHUNK-bit ripple of full-subtractor cells.
module chunked_serial_subtractor_chunk #(
   parameter int unsigned CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             b_in,
   output logic [CHUNK-1:0] diff,
   output logic             b_out
);

   logic [CHUNK:0] chain;

   // Borrow ripples from bit 0 upward; a cell borrows when a<b, or a==b with a borrow in.
   always_comb begin
      chain    = '0;
      diff     = '0;
      chain[0] = b_in;
      for (int i = 0; i < int'(CHUNK); i++) begin
         diff[i]    = a[i] ^ b[i] ^ chain[i];
         chain[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain[i]);
      end
      b_out = chain[CHUNK];
   end

endmodule

// File: rtl/chunked_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - b_in, CHUNK bits per cycle, valid/ready on both sides.
module chunked_serial_subtractor
   import chunked_serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             b_out,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned IDXW   = $clog2(NCHUNK) + 1;

   if (!geometry_ok(WIDTH, CHUNK)) begin : g_bad_geometry
      $error("chunked_serial_subtractor: WIDTH must be >= 2 and a multiple of CHUNK");
   end

   state_t            state;
   logic [IDXW-1:0]   idx;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic              borrow_q;
   logic [31:0]       ofs;
   logic [CHUNK-1:0]  chunk_a;
   logic [CHUNK-1:0]  chunk_b;
   logic [CHUNK-1:0]  chunk_d;
   logic              chunk_bo;
   logic [WIDTH-1:0]  diff_nx;
   logic              last;

   // Select the current operand slices and splice the new slice into the running result.
   always_comb begin
      ofs     = 32'(idx) * 32'(CHUNK);
      chunk_a = a_q[ofs +: CHUNK];
      chunk_b = b_q[ofs +: CHUNK];
      diff_nx = diff;
      diff_nx[ofs +: CHUNK] = chunk_d;
      last    = (idx == IDXW'(NCHUNK - 1));
   end

   chunked_serial_subtractor_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (chunk_a),
      .b     (chunk_b),
      .b_in  (borrow_q),
      .diff  (chunk_d),
      .b_out (chunk_bo)
   );

   // Control FSM with registered handshakes, result and flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         borrow_q  <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         diff      <= '0;
         b_out     <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= b;
                  borrow_q <= b_in;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               diff     <= diff_nx;
               borrow_q <= chunk_bo;
               idx      <= idx + IDXW'(1);
               if (last) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  b_out     <= chunk_bo;
                  ovf       <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ diff_nx[WIDTH-1]);
                  zero      <= (diff_nx == '0);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
